// File: rtl/ps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic YES  = 1'b1;
    localparam logic NO   = 1'b0;

    localparam int unsigned CNT_W = 21;

    localparam int unsigned DEF_INHIBIT_CYCLES = 7425;
    localparam int unsigned DEF_START_TIMEOUT  = 1113750;
    localparam int unsigned DEF_PACKET_TIMEOUT = 148500;

    // Falls 1..10 shift out data, parity and stop; the 11th fall carries the ack.
    localparam logic [3:0] ACK_BIT = 4'd10;

    typedef logic [7:0]       cmd_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SEND,
        S_WAIT_IDLE
    } ps2_state_t;

    // Saturating increment: the cycle counter never wraps inside one state.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Bits shifted out LSB first after the start bit: data, odd parity, stop.
    function automatic logic [9:0] frame(input cmd_t b);
        return {HIGH, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake and status bundle between a command source and ps2_tx.
interface ps2_tx_if;
    import ps2_tx_pkg::*;

    logic command_valid;
    logic command_ready;
    cmd_t command;
    logic busy;
    logic done;
    logic ack_error;
    logic timeout_error;

    modport master (
        output command_valid, command,
        input  command_ready, busy, done, ack_error, timeout_error
    );

    modport slave (
        input  command_valid, command,
        output command_ready, busy, done, ack_error, timeout_error
    );

endinterface

// File: rtl/ps2_tx_sync.sv
// 2-FF synchronisers for the PS/2 clock and data pads plus a clock falling-edge pulse.
// Shared with the receiver, which needs the same synced levels and clock fall.
module ps2_sync
    import ps2_tx_pkg::*;
(
    input  logic clk,
    input  logic reset_low,
    input  logic ps2_clk_pin,
    input  logic ps2_data_pin,
    output logic clk_level,
    output logic data_level,
    output logic clk_fall
);

    logic [1:0] clk_meta;
    logic [1:0] data_meta;
    logic       clk_prev;

    // Synchronise both pads; idle lines are high, so reset to high.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            clk_meta  <= {HIGH, HIGH};
            data_meta <= {HIGH, HIGH};
            clk_prev  <= HIGH;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk_pin};
            data_meta <= {data_meta[0], ps2_data_pin};
            clk_prev  <= clk_meta[1];
        end
    end

    assign clk_level  = clk_meta[1];
    assign data_level = data_meta[1];
    assign clk_fall   = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit, shifts a
// command byte out on device clock falls and checks the device acknowledge.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int unsigned PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
    input  logic      clk,
    input  logic      reset_low,
    input  logic      ps2_clk_pin,
    input  logic      ps2_data_pin,
    output logic      ps2_clk_drive_low,
    output logic      ps2_data_drive_low,
    ps2_tx_if.slave   cmd
);

    localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t START_LAST   = cnt_t'(START_TIMEOUT - 1);
    localparam cnt_t PACKET_LAST  = cnt_t'(PACKET_TIMEOUT - 1);

    ps2_state_t state;
    logic [9:0] shift;
    logic [3:0] bit_cnt;
    cnt_t       counter;
    logic       seen_fall;
    logic       ack_bad;
    logic       clk_drive_q;
    logic       data_drive_q;
    logic       ready_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_error_q;
    logic       timeout_error_q;

    logic clk_level;
    logic data_level;
    logic clk_fall;
    logic timeout;

    ps2_sync u_sync (
        .clk          (clk),
        .reset_low    (reset_low),
        .ps2_clk_pin  (ps2_clk_pin),
        .ps2_data_pin (ps2_data_pin),
        .clk_level    (clk_level),
        .data_level   (data_level),
        .clk_fall     (clk_fall)
    );

    // Start timeout applies only until the first device fall; packet timeout always.
    always_comb begin
        timeout = NO;
        if (state == S_SEND) begin
            timeout = (!seen_fall && counter == START_LAST) || (counter == PACKET_LAST);
        end
    end

    // Transfer sequencer with registered line drives and status outputs.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state           <= S_IDLE;
            shift           <= '0;
            bit_cnt         <= '0;
            counter         <= '0;
            seen_fall       <= NO;
            ack_bad         <= NO;
            clk_drive_q     <= LOW;
            data_drive_q    <= LOW;
            ready_q         <= NO;
            busy_q          <= NO;
            done_q          <= NO;
            ack_error_q     <= NO;
            timeout_error_q <= NO;
        end else begin
            done_q          <= NO;
            ack_error_q     <= NO;
            timeout_error_q <= NO;
            unique case (state)
                S_IDLE: begin
                    ready_q <= YES;
                    busy_q  <= NO;
                    if (cmd.command_valid && ready_q) begin
                        shift       <= frame(cmd.command);
                        clk_drive_q <= HIGH;
                        counter     <= '0;
                        ready_q     <= NO;
                        busy_q      <= YES;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    counter <= sat_inc(counter);
                    if (counter == INHIBIT_LAST) begin
                        data_drive_q <= HIGH;
                        state        <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    clk_drive_q <= LOW;
                    counter     <= '0;
                    bit_cnt     <= '0;
                    seen_fall   <= NO;
                    ack_bad     <= NO;
                    state       <= S_SEND;
                end
                S_SEND: begin
                    counter <= sat_inc(counter);
                    if (timeout) begin
                        clk_drive_q     <= LOW;
                        data_drive_q    <= LOW;
                        done_q          <= YES;
                        timeout_error_q <= YES;
                        ready_q         <= YES;
                        busy_q          <= NO;
                        state           <= S_IDLE;
                    end else if (clk_fall) begin
                        seen_fall <= YES;
                        if (bit_cnt != ACK_BIT) begin
                            data_drive_q <= ~shift[0];
                            shift        <= {1'b0, shift[9:1]};
                            bit_cnt      <= bit_cnt + 1'b1;
                        end else begin
                            ack_bad      <= data_level;
                            data_drive_q <= LOW;
                            state        <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        done_q      <= YES;
                        ack_error_q <= ack_bad;
                        ready_q     <= YES;
                        busy_q      <= NO;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ps2_clk_drive_low  = clk_drive_q;
    assign ps2_data_drive_low = data_drive_q;
    assign cmd.command_ready  = ready_q;
    assign cmd.busy           = busy_q;
    assign cmd.done           = done_q;
    assign cmd.ack_error      = ack_error_q;
    assign cmd.timeout_error  = timeout_error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain line model and a PS/2 device model.
module tb_ps2_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_low;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_drv;
    logic data_drv;
    logic ps2_clk_pin;
    logic ps2_data_pin;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_pin  = ~(clk_drv | dev_clk_low);
    assign ps2_data_pin = ~(data_drv | dev_data_low);

    ps2_tx_if bus ();

    ps2_tx #(
        .INHIBIT_CYCLES (10),
        .START_TIMEOUT  (200),
        .PACKET_TIMEOUT (1000)
    ) dut (
        .clk                (clk),
        .reset_low          (reset_low),
        .ps2_clk_pin        (ps2_clk_pin),
        .ps2_data_pin       (ps2_data_pin),
        .ps2_clk_drive_low  (clk_drv),
        .ps2_data_drive_low (data_drv),
        .cmd                (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer a byte; returns at the first negedge after the handshake edge.
    task automatic send_start(input logic [7:0] b, input bit hold);
        @(negedge clk);
        bus.command_valid = 1'b1;
        bus.command       = b;
        @(negedge clk);
        check("hs_busy", bus.busy, 1);
        check("hs_clk_drive", clk_drv, 1);
        check("hs_data_drive", data_drv, 0);
        if (!hold) bus.command_valid = 1'b0;
    endtask

    // Clock held alone for exactly 10 cycles, start bit, then clock release 1 cycle later.
    task automatic inhibit_check();
        int n = 0;
        while (!data_drv && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_len", n, 10);
        check("start_with_clk_low", clk_drv, 1);
        @(negedge clk);
        check("release_clk", clk_drv, 0);
        check("release_data", data_drv, 1);
    endtask

    // Device: 40-cycle clock, reads on rising edge. bits[7:0] data, [8] parity, [9] stop.
    task automatic device_rx(input int nbits, input logic do_ack, output logic [10:0] bits);
        bits = '0;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            bits[i-1]   = ps2_data_pin;
            dev_clk_low = 1'b0;
            if (i == 11) dev_data_low = 1'b0;
            if (i == nbits || i == 11) return;
            if (i == 10) dev_data_low = do_ack;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!bus.done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
    endtask

    task automatic transfer(input logic [7:0] b, input logic exp_par, input logic do_ack);
        logic [10:0] bits;
        send_start(b, 1'b0);
        inhibit_check();
        device_rx(11, do_ack, bits);
        check("rx_data", bits[7:0], b);
        check("rx_parity", bits[8], exp_par);
        check("rx_stop", bits[9], 1);
        wait_done(100);
        check("ack_error", bus.ack_error, !do_ack);
        check("timeout_error", bus.timeout_error, 0);
        check("ready_after", bus.command_ready, 1);
        check("clk_drive_after", clk_drv, 0);
        check("data_drive_after", data_drv, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int n;
        int dones;

        reset_low         = 1'b0;
        bus.command_valid = 1'b0;
        bus.command       = 8'h00;
        #1;
        check("rst_clk_drive", clk_drv, 0);
        check("rst_data_drive", data_drv, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack", bus.ack_error, 0);
        check("rst_timeout", bus.timeout_error, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.command_ready, 0);
        repeat (3) @(negedge clk);
        reset_low = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.command_ready, 1);

        transfer(8'hED, 1'b1, 1'b1);
        transfer(8'h01, 1'b0, 1'b1);
        transfer(8'hFF, 1'b1, 1'b1);
        // No ack from the device: ack_error with done.
        transfer(8'hF4, 1'b0, 1'b0);

        // Device never clocks: start timeout 200 cycles after clock release.
        send_start(8'h12, 1'b0);
        inhibit_check();
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 200);
        check("timeout_flag", bus.timeout_error, 1);
        check("timeout_ack", bus.ack_error, 0);
        check("timeout_clk_drive", clk_drv, 0);
        check("timeout_data_drive", data_drv, 0);
        check("timeout_ready", bus.command_ready, 1);
        transfer(8'hFF, 1'b1, 1'b1);

        // Reset after the 4th data bit releases the lines asynchronously.
        send_start(8'h30, 1'b0);
        inhibit_check();
        device_rx(4, 1'b1, bits);
        check("abort_low_bits", bits[3:0], 4'h0);
        check("abort_data_drive_pre", data_drv, 1);
        #2;
        reset_low = 1'b0;
        #1;
        check("abort_clk_drive", clk_drv, 0);
        check("abort_data_drive", data_drv, 0);
        check("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset_low = 1'b1;
        @(negedge clk);
        check("abort_ready", bus.command_ready, 1);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        check("abort_idle_busy", bus.busy, 0);

        // Valid held across two bytes: second handshake only after first done.
        send_start(8'h55, 1'b1);
        bus.command = 8'hAA;
        inhibit_check();
        device_rx(11, 1'b1, bits);
        check("held1_data", bits[7:0], 8'h55);
        check("held1_parity", bits[8], 1);
        check("held1_not_ready", bus.command_ready, 0);
        wait_done(100);
        check("held1_ack", bus.ack_error, 0);
        check("held1_ready", bus.command_ready, 1);
        @(negedge clk);
        check("held2_busy", bus.busy, 1);
        check("held2_clk_drive", clk_drv, 1);
        bus.command_valid = 1'b0;
        inhibit_check();
        device_rx(11, 1'b1, bits);
        check("held2_data", bits[7:0], 8'hAA);
        check("held2_parity", bits[8], 1);
        wait_done(100);
        check("held2_ack", bus.ack_error, 0);
        repeat (20) @(negedge clk);
        check("held_no_third", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
